// File: rtl/booth4_multiplier_param.sv
// Iterative radix-4 Booth multiplier with per-operand sign selects, abort and valid/ready on both sides.
// Optional early termination is enabled by defining BOOTH4_MUL_EARLY_TERM_EN.
module booth4_multiplier_param #(
    parameter int WIDTH     = 32,
    parameter int DIGITS_PC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_op1,
    input  logic [WIDTH-1:0]     in_op2,
    input  logic                 in_op1_signed,
    input  logic                 in_op2_signed,
    input  logic                 in_valid,
    output logic                 out_ready,
    input  logic                 in_abort,
    output logic [2*WIDTH-1:0]   out_res,
    output logic                 out_valid,
    input  logic                 in_ready,
    output logic                 out_busy
);

    localparam int RES_WIDTH = 2 * WIDTH;
    localparam int ACC_W     = RES_WIDTH + 2;
    localparam int N         = WIDTH / (2 * DIGITS_PC);
    localparam int CNT_W     = (N > 1) ? $clog2(N) : 1;
    localparam int STEP      = 2 * DIGITS_PC;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               r_state;
    logic                 r_out_ready;
    logic                 r_out_valid;
    logic                 r_out_busy;
    logic [RES_WIDTH-1:0] r_res;
    logic [ACC_W-1:0]     r_acc;
    logic [ACC_W-1:0]     r_mcand;
    logic [WIDTH:0]       r_mplr;
    logic [CNT_W-1:0]     r_cnt;

    logic [ACC_W-1:0]     w_op1_ext;
    logic                 w_top_dig;
    logic [ACC_W-1:0]     w_acc_init;
    logic [WIDTH:0]       w_mplr_nxt;
    logic                 w_early;
    logic                 w_last;

    assign w_op1_ext  = {{(ACC_W-WIDTH){in_op1_signed & in_op1[WIDTH-1]}}, in_op1};
    // The extension-only top digit is +1 exactly when op2 is unsigned with its MSB set,
    // so its partial product is preloaded into the accumulator at accept time.
    assign w_top_dig  = ~in_op2_signed & in_op2[WIDTH-1];
    assign w_acc_init = w_top_dig ? (w_op1_ext << WIDTH) : '0;

    // Fill with the MSB so the fill never breaks the uniformity test of the unretired bits.
    assign w_mplr_nxt = {{STEP{r_mplr[WIDTH]}}, r_mplr[WIDTH:STEP]};

`ifdef BOOTH4_MUL_EARLY_TERM_EN
    assign w_early = (&w_mplr_nxt) | ~(|w_mplr_nxt);
`else
    assign w_early = 1'b0;
`endif

    assign w_last = (r_cnt == CNT_W'(N - 1)) | w_early;

    logic [2:0]       w_grp;
    logic             w_one;
    logic             w_two;
    logic             w_neg;
    logic [ACC_W-1:0] w_mag;
    logic [ACC_W-1:0] w_sum;

    always_comb begin
        w_sum = r_acc;
        w_grp = '0;
        w_one = 1'b0;
        w_two = 1'b0;
        w_neg = 1'b0;
        w_mag = '0;
        for (int j = 0; j < DIGITS_PC; j++) begin
            w_grp = r_mplr[2*j +: 3];
            w_one = w_grp[1] ^ w_grp[0];
            w_two = (w_grp[2] & ~w_grp[1] & ~w_grp[0]) | (~w_grp[2] & w_grp[1] & w_grp[0]);
            w_neg = w_grp[2] & ~(w_grp[1] & w_grp[0]);
            w_mag = w_one ? (r_mcand << (2*j)) : (w_two ? (r_mcand << (2*j+1)) : '0);
            // Negation: one's complement here, the +1 enters as the adder carry-in.
            w_sum = w_sum + (w_mag ^ {ACC_W{w_neg}}) + ACC_W'(w_neg);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out_ready <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_busy  <= 1'b0;
            r_res       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplr      <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state     <= CALC;
                        r_out_ready <= 1'b0;
                        r_out_busy  <= 1'b1;
                        r_acc       <= w_acc_init;
                        r_mcand     <= w_op1_ext;
                        r_mplr      <= {in_op2, 1'b0};
                        r_cnt       <= '0;
                    end
                end
                CALC: begin
                    if (in_abort) begin
                        r_state     <= IDLE;
                        r_out_ready <= 1'b1;
                        r_out_busy  <= 1'b0;
                    end else begin
                        r_acc   <= w_sum;
                        r_mcand <= r_mcand << STEP;
                        r_mplr  <= w_mplr_nxt;
                        r_cnt   <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_res       <= w_sum[RES_WIDTH-1:0];
                        end
                    end
                end
                DONE: begin
                    if (in_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_out_ready <= 1'b1;
                        r_out_busy  <= 1'b0;
                        r_res       <= '0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_ready <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_out_busy  <= 1'b0;
                    r_res       <= '0;
                end
            endcase
        end
    end

    assign out_ready = r_out_ready;
    assign out_valid = r_out_valid;
    assign out_busy  = r_out_busy;
    assign out_res   = r_res;

endmodule

// File: tb/tb_booth4_multiplier_param.sv
// Scoreboard bench: an 8-bit/1-digit and a 32-bit/2-digit multiplier checked against an arithmetic model.
module tb_booth4_multiplier_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] op1 [2];
    logic [31:0] op2 [2];
    logic        s1 [2];
    logic        s2 [2];
    logic        vld [2];
    logic        abt [2];
    logic        rdy [2];
    logic        ordy [2];
    logic        ovld [2];
    logic        obusy [2];
    logic [15:0] res8;
    logic [63:0] res32;
    wire  [63:0] w_res [2];

    assign w_res[0] = {48'h0, res8};
    assign w_res[1] = res32;

    booth4_multiplier_param #(.WIDTH(8), .DIGITS_PC(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_op1(op1[0][7:0]), .in_op2(op2[0][7:0]),
        .in_op1_signed(s1[0]), .in_op2_signed(s2[0]),
        .in_valid(vld[0]), .out_ready(ordy[0]), .in_abort(abt[0]),
        .out_res(res8), .out_valid(ovld[0]), .in_ready(rdy[0]), .out_busy(obusy[0])
    );

    booth4_multiplier_param #(.WIDTH(32), .DIGITS_PC(2)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_op1(op1[1]), .in_op2(op2[1]),
        .in_op1_signed(s1[1]), .in_op2_signed(s2[1]),
        .in_valid(vld[1]), .out_ready(ordy[1]), .in_abort(abt[1]),
        .out_res(res32), .out_valid(ovld[1]), .in_ready(rdy[1]), .out_busy(obusy[1])
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Plain modular arithmetic on sign/zero-extended operands.
    function automatic logic [63:0] model(input int d, input logic [31:0] a, input logic [31:0] b,
                                          input bit sa, input bit sb);
        logic [63:0] ea, eb, p;
        if (d == 0) begin
            ea = {{56{sa & a[7]}}, a[7:0]};
            eb = {{56{sb & b[7]}}, b[7:0]};
            p  = ea * eb;
            return {48'h0, p[15:0]};
        end
        ea = {{32{sa & a[31]}}, a};
        eb = {{32{sb & b[31]}}, b};
        return ea * eb;
    endfunction

    // Expected CALC cycles: N, or the first cycle after which the unretired bits plus overlap are uniform.
    function automatic int exp_lat(input int d, input logic [31:0] b);
        int w, dpc, n;
        logic [32:0] e;
        w   = (d == 0) ? 8 : 32;
        dpc = (d == 0) ? 1 : 2;
        n   = w / (2 * dpc);
        e   = (d == 0) ? {24'h0, b[7:0], 1'b0} : {b, 1'b0};
`ifdef BOOTH4_MUL_EARLY_TERM_EN
        for (int k = 1; k < n; k++) begin
            bit uni;
            uni = 1'b1;
            for (int i = 2 * dpc * k; i <= w; i++)
                if (e[i] != e[w]) uni = 1'b0;
            if (uni) return k;
        end
`endif
        return n;
    endfunction

    always @(negedge clk) begin
        if (ovld[0] && rdy[0]) begin
            if (q0.size() == 0) check_eq("unexp_vld8", ovld[0], 0);
            else                check_eq("res8", w_res[0], q0.pop_front());
        end
        if (ovld[1] && rdy[1]) begin
            if (q1.size() == 0) check_eq("unexp_vld32", ovld[1], 0);
            else                check_eq("res32", w_res[1], q1.pop_front());
        end
    end

    task automatic wait_ready(input int d);
        int t = 0;
        while (!ordy[d] && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("ready_wait", ordy[d], 1);
    endtask

    task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b,
                         input bit sa, input bit sb, input logic [63:0] exp, input bit hold);
        int lat;
        wait_ready(d);
        rdy[d] = !hold;
        op1[d] = a; op2[d] = b; s1[d] = sa; s2[d] = sb; vld[d] = 1'b1;
        if (d == 0) q0.push_back(exp);
        else        q1.push_back(exp);
        @(posedge clk); #1;
        vld[d] = 1'b0;
        op1[d] = $urandom; op2[d] = $urandom; s1[d] = ~sa; s2[d] = ~sb;
        lat = 0;
        while (!ovld[d] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", lat, exp_lat(d, b));
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                check_eq("hold_vld", ovld[d], 1);
                check_eq("hold_res", w_res[d], exp);
                check_eq("hold_ordy", ordy[d], 0);
                op1[d] = $urandom; op2[d] = $urandom;
                vld[d] = ~vld[d]; abt[d] = ~abt[d];
                @(posedge clk); #1;
            end
            vld[d] = 1'b0; abt[d] = 1'b0; rdy[d] = 1'b1;
        end
        @(posedge clk); #1;
        check_eq("post_hs_vld", ovld[d], 0);
    endtask

    initial begin
        logic [31:0] a, b;
        bit sa, sb;
        for (int d = 0; d < 2; d++) begin
            op1[d] = '0; op2[d] = '0; s1[d] = 0; s2[d] = 0;
            vld[d] = 0; abt[d] = 0; rdy[d] = 1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq("rst_ordy", ordy[d], 1);
            check_eq("rst_ovld", ovld[d], 0);
            check_eq("rst_busy", obusy[d], 0);
            check_eq("rst_res", w_res[d], 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(0, 32'hFF, 32'hFF, 0, 0, 64'hFE01, 0);
        issue(0, 32'h80, 32'h80, 1, 1, 64'h4000, 0);
        issue(0, 32'h80, 32'hFF, 1, 0, 64'h8080, 0);
        issue(0, 32'h80, 32'hFF, 0, 1, 64'hFF80, 0);
        issue(1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1, 1, 64'h3FFFFFFF00000001, 0);
        issue(1, 32'h1234, 32'h3, 0, 0, 64'h369C, 0);
        issue(0, 32'h5A, 32'hC3, 1, 0, model(0, 32'h5A, 32'hC3, 1, 0), 1);

        // Abort during the third CALC cycle.
        wait_ready(0);
        op1[0] = 32'h12; op2[0] = 32'h34; vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        check_eq("calc_busy", obusy[0], 1);
        check_eq("calc_ordy", ordy[0], 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abt[0] = 1'b1;
        @(posedge clk); #1;
        abt[0] = 1'b0;
        check_eq("abort_ordy", ordy[0], 1);
        check_eq("abort_busy", obusy[0], 0);
        repeat (6) @(posedge clk);
        #1;
        check_eq("abort_no_vld", ovld[0], 0);
        issue(0, 32'd3, 32'd5, 0, 0, 64'd15, 0);

        // Asynchronous reset in the middle of an operation.
        wait_ready(1);
        op1[1] = 32'hDEAD; op2[1] = 32'hBEEF; vld[1] = 1'b1;
        @(posedge clk); #1;
        vld[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_ordy", ordy[1], 1);
        check_eq("mid_rst_busy", obusy[1], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check_eq("mid_rst_no_vld", ovld[1], 0);

        for (int i = 0; i < 24; i++) begin
            for (int d = 0; d < 2; d++) begin
                case (i % 6)
                    0: a = 32'h0;
                    1: a = 32'hFFFFFFFF;
                    2: a = (d == 0) ? 32'h80 : 32'h80000000;
                    default: a = $urandom;
                endcase
                b  = (i % 5 == 0) ? ((d == 0) ? 32'h7F : 32'h7FFFFFFF) : $urandom;
                if (d == 0) begin a = a & 32'hFF; b = b & 32'hFF; end
                sa = 1'($urandom_range(0, 1));
                sb = 1'($urandom_range(0, 1));
                issue(d, a, b, sa, sb, model(d, a, b, sa, sb), 0);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check_eq("q8_left", q0.size(), 0);
        check_eq("q32_left", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
